piece_ctrl: RTL and testbench

//  Active-tetromino controller; sits directly upstream of the board, which consumes its coords, candidates and pulses.

---
 rtl/piece_ctrl_pkg.sv | 79 +++++++
 rtl/piece_cells.sv | 24 ++
 rtl/piece_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_piece_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/piece_ctrl_pkg.sv
// Shared types for the active-piece controller: block colours, per-cell
// shape offsets, FSM states, spawn/gravity defaults and the shape table.
package piece_ctrl_pkg;

    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        I_BLK = 3'd1,
        O_BLK = 3'd2,
        T_BLK = 3'd3,
        S_BLK = 3'd4,
        Z_BLK = 3'd5,
        J_BLK = 3'd6,
        L_BLK = 3'd7
    } block_color;

    // One cell offset inside the 4x4 bounding box.
    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } cell_off_t;

    // Element [3] is cell 0, element [0] is cell 3.
    typedef cell_off_t [3:0] shape_offs_t;

    typedef enum logic [2:0] {
        S_SPAWN     = 3'd0,
        S_PLAY      = 3'd1,
        S_LOCK      = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_OVER      = 3'd4
`ifdef PIECE_HARD_DROP_EN
        ,
        S_DROPPING  = 3'd5
`endif
    } piece_state_t;

    localparam logic [4:0]  SPAWN_X_DEF        = 5'd3;
    localparam logic [4:0]  SPAWN_Y_DEF        = 5'd0;
    localparam int unsigned GRAVITY_FRAMES_DEF = 32'd48;
    localparam int unsigned SOFT_FRAMES_DEF    = 32'd3;

    // Each nibble is one cell as {dx,dy}; the leftmost nibble is cell 0.
    function automatic shape_offs_t shape_offsets(input block_color color, input logic [1:0] rot);
        logic [15:0] tbl;
        case ({color, rot})
            {I_BLK, 2'd0}: tbl = 16'h159D;
            {I_BLK, 2'd1}: tbl = 16'h89AB;
            {I_BLK, 2'd2}: tbl = 16'h26AE;
            {I_BLK, 2'd3}: tbl = 16'h4567;
            {O_BLK, 2'd0},
            {O_BLK, 2'd1},
            {O_BLK, 2'd2},
            {O_BLK, 2'd3}: tbl = 16'h4859;
            {T_BLK, 2'd0}: tbl = 16'h4159;
            {T_BLK, 2'd1}: tbl = 16'h4596;
            {T_BLK, 2'd2}: tbl = 16'h1596;
            {T_BLK, 2'd3}: tbl = 16'h4156;
            {S_BLK, 2'd0}: tbl = 16'h4815;
            {S_BLK, 2'd1}: tbl = 16'h459A;
            {S_BLK, 2'd2}: tbl = 16'h5926;
            {S_BLK, 2'd3}: tbl = 16'h0156;
            {Z_BLK, 2'd0}: tbl = 16'h0459;
            {Z_BLK, 2'd1}: tbl = 16'h8596;
            {Z_BLK, 2'd2}: tbl = 16'h156A;
            {Z_BLK, 2'd3}: tbl = 16'h4152;
            {J_BLK, 2'd0}: tbl = 16'h0159;
            {J_BLK, 2'd1}: tbl = 16'h4856;
            {J_BLK, 2'd2}: tbl = 16'h159A;
            {J_BLK, 2'd3}: tbl = 16'h4526;
            {L_BLK, 2'd0}: tbl = 16'h8159;
            {L_BLK, 2'd1}: tbl = 16'h456A;
            {L_BLK, 2'd2}: tbl = 16'h1592;
            {L_BLK, 2'd3}: tbl = 16'h0456;
            default:       tbl = 16'h0000;
        endcase
        return shape_offs_t'(tbl);
    endfunction

endpackage

// File: rtl/piece_cells.sv
// Turns a piece origin, rotation and colour into the four packed cell
// coordinates (cell k at [19-5k -: 5]). Coordinates wrap modulo 32, so a
// column left of 0 shows up as 31 for the board to reject.
module piece_cells
    import piece_ctrl_pkg::*;
(
    input  logic [4:0]  org_x_i,
    input  logic [4:0]  org_y_i,
    input  logic [1:0]  rot_i,
    input  block_color  color_i,
    output logic [19:0] x_cells_o,
    output logic [19:0] y_cells_o
);

    shape_offs_t offs_s;

    assign offs_s = shape_offsets(color_i, rot_i);

    for (genvar k = 0; k < 4; k++) begin : g_cell
        assign x_cells_o[19-5*k -: 5] = org_x_i + {3'b000, offs_s[3-k].dx};
        assign y_cells_o[19-5*k -: 5] = org_y_i + {3'b000, offs_s[3-k].dy};
    end

endmodule

// File: rtl/piece_ctrl.sv
// Active-tetromino controller. Keeps origin, rotation and colour of the
// falling piece, applies gravity and edge-detected key moves (sampled on
// frame strobes) when the board allows them, locks the piece, waits for the
// board's line clear and spawns the next piece.
// Optional feature: define PIECE_HARD_DROP_EN to add the hard-drop state,
// which walks the piece down one row every second clock until it lands.
module piece_ctrl
    import piece_ctrl_pkg::*;
#(
    parameter int unsigned GRAVITY_FRAMES = GRAVITY_FRAMES_DEF,
    parameter int unsigned SOFT_FRAMES    = SOFT_FRAMES_DEF,
    parameter logic [4:0]  SPAWN_X        = SPAWN_X_DEF,
    parameter logic [4:0]  SPAWN_Y        = SPAWN_Y_DEF
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk_rising_edge,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_rot_l,
    input  logic        key_rot_r,
    input  logic        soft_drop,
    input  logic        hard_drop,
    input  block_color  next_block,
    input  logic [4:0]  can_move,
    input  logic        BOARD_BUSY,
    output logic [19:0] x_block,
    output logic [19:0] y_block,
    output logic [19:0] save_xblock,
    output logic [19:0] save_yblock,
    output logic [19:0] x_move_left,
    output logic [19:0] y_move_left,
    output logic [19:0] x_move_right,
    output logic [19:0] y_move_right,
    output logic [19:0] x_move_down,
    output logic [19:0] y_move_down,
    output logic [19:0] x_rotate_left,
    output logic [19:0] y_rotate_left,
    output logic [19:0] x_rotate_right,
    output logic [19:0] y_rotate_right,
    output block_color  block,
    output logic        get_new_block,
    output logic        game_over
);

    localparam int unsigned MAX_FRAMES = (GRAVITY_FRAMES > SOFT_FRAMES) ? GRAVITY_FRAMES : SOFT_FRAMES;
    localparam int          CNT_W      = $clog2(MAX_FRAMES + 32'd1);
    localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_FRAMES - 32'd1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_FRAMES - 32'd1);

    // can_move bit positions
    localparam int CM_LEFT  = 4;
    localparam int CM_RIGHT = 3;
    localparam int CM_ROT_R = 2;
    localparam int CM_ROT_L = 1;
    localparam int CM_DOWN  = 0;

    // key vector bit positions {rot_r, rot_l, left, right}
    localparam int K_ROT_R = 3;
    localparam int K_ROT_L = 2;
    localparam int K_LEFT  = 1;
    localparam int K_RIGHT = 0;

    piece_state_t     state_q, state_d;
    logic [4:0]       org_x_q, org_x_d;
    logic [4:0]       org_y_q, org_y_d;
    logic [1:0]       rot_q, rot_d;
    block_color       color_q, color_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       hist_q, hist_d;
    logic [19:0]      save_x_q, save_x_d;
    logic [19:0]      save_y_q, save_y_d;
    logic             save_sel_q, save_sel_d;
    logic             get_new_q, get_new_d;
    logic             game_over_q, game_over_d;
    logic             wait_first_q, wait_first_d;
    logic             move_s;
    logic             tick_s;
    logic [CNT_W-1:0] last_s;
    logic [3:0]       keys_s;
    logic [3:0]       edge_s;

`ifdef PIECE_HARD_DROP_EN
    logic hd_hist_q, hd_hist_d;
    logic drop_phase_q, drop_phase_d;
    logic hd_edge_s;
    assign hd_edge_s = hard_drop & ~hd_hist_q;
`else
    logic unused_hard_drop_s;
    assign unused_hard_drop_s = hard_drop;
`endif

    assign keys_s = {key_rot_r, key_rot_l, key_left, key_right};
    assign edge_s = keys_s & ~hist_q;
    assign last_s = soft_drop ? SOFT_LAST : GRAV_LAST;
    // >= so that switching to a shorter limit mid-count ticks on the next strobe
    assign tick_s = (cnt_q >= last_s);

    piece_cells u_cur (
        .org_x_i(org_x_q), .org_y_i(org_y_q), .rot_i(rot_q), .color_i(color_q),
        .x_cells_o(x_block), .y_cells_o(y_block)
    );
    piece_cells u_left (
        .org_x_i(org_x_q - 5'd1), .org_y_i(org_y_q), .rot_i(rot_q), .color_i(color_q),
        .x_cells_o(x_move_left), .y_cells_o(y_move_left)
    );
    piece_cells u_right (
        .org_x_i(org_x_q + 5'd1), .org_y_i(org_y_q), .rot_i(rot_q), .color_i(color_q),
        .x_cells_o(x_move_right), .y_cells_o(y_move_right)
    );
    piece_cells u_down (
        .org_x_i(org_x_q), .org_y_i(org_y_q + 5'd1), .rot_i(rot_q), .color_i(color_q),
        .x_cells_o(x_move_down), .y_cells_o(y_move_down)
    );
    piece_cells u_rot_l (
        .org_x_i(org_x_q), .org_y_i(org_y_q), .rot_i(rot_q - 2'd1), .color_i(color_q),
        .x_cells_o(x_rotate_left), .y_cells_o(y_rotate_left)
    );
    piece_cells u_rot_r (
        .org_x_i(org_x_q), .org_y_i(org_y_q), .rot_i(rot_q + 2'd1), .color_i(color_q),
        .x_cells_o(x_rotate_right), .y_cells_o(y_rotate_right)
    );

    // Erase cells: the pre-move position for the cycle after a move, else the current one.
    assign save_xblock   = save_sel_q ? save_x_q : x_block;
    assign save_yblock   = save_sel_q ? save_y_q : y_block;
    assign block         = color_q;
    assign get_new_block = get_new_q;
    assign game_over     = game_over_q;

    // Next-state logic: piece FSM, one action per strobe, lock/spawn handshake.
    always_comb begin
        state_d      = state_q;
        org_x_d      = org_x_q;
        org_y_d      = org_y_q;
        rot_d        = rot_q;
        color_d      = color_q;
        cnt_d        = cnt_q;
        hist_d       = hist_q;
        get_new_d    = 1'b0;
        game_over_d  = game_over_q;
        wait_first_d = wait_first_q;
        move_s       = 1'b0;
`ifdef PIECE_HARD_DROP_EN
        hd_hist_d    = hd_hist_q;
        drop_phase_d = drop_phase_q;
`endif

        if (frame_clk_rising_edge && (state_q != S_OVER)) begin
            hist_d = keys_s;
`ifdef PIECE_HARD_DROP_EN
            hd_hist_d = hard_drop;
`endif
        end else begin
            hist_d = hist_q;
        end

        case (state_q)
            S_SPAWN: begin
                org_x_d = SPAWN_X;
                org_y_d = SPAWN_Y;
                rot_d   = 2'd0;
                color_d = next_block;
                cnt_d   = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (frame_clk_rising_edge) begin
                    cnt_d = tick_s ? '0 : (cnt_q + CNT_W'(1));
                    if (tick_s) begin
                        if (can_move[CM_DOWN]) begin
                            org_y_d = org_y_q + 5'd1;
                            move_s  = 1'b1;
                        end else begin
                            state_d   = S_LOCK;
                            get_new_d = 1'b1;
                        end
`ifdef PIECE_HARD_DROP_EN
                    end else if (hd_edge_s) begin
                        state_d      = S_DROPPING;
                        drop_phase_d = 1'b0;
`endif
                    end else if (edge_s[K_ROT_R]) begin
                        if (can_move[CM_ROT_R]) begin
                            rot_d  = rot_q + 2'd1;
                            move_s = 1'b1;
                        end else begin
                            move_s = 1'b0;
                        end
                    end else if (edge_s[K_ROT_L]) begin
                        if (can_move[CM_ROT_L]) begin
                            rot_d  = rot_q - 2'd1;
                            move_s = 1'b1;
                        end else begin
                            move_s = 1'b0;
                        end
                    end else if (edge_s[K_LEFT]) begin
                        if (can_move[CM_LEFT]) begin
                            org_x_d = org_x_q - 5'd1;
                            move_s  = 1'b1;
                        end else begin
                            move_s = 1'b0;
                        end
                    end else if (edge_s[K_RIGHT]) begin
                        if (can_move[CM_RIGHT]) begin
                            org_x_d = org_x_q + 5'd1;
                            move_s  = 1'b1;
                        end else begin
                            move_s = 1'b0;
                        end
                    end else begin
                        move_s = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
`ifdef PIECE_HARD_DROP_EN
            S_DROPPING: begin
                // Step on every other clock so the board can repaint in between.
                drop_phase_d = ~drop_phase_q;
                if (drop_phase_q) begin
                    if (can_move[CM_DOWN]) begin
                        org_y_d = org_y_q + 5'd1;
                        move_s  = 1'b1;
                    end else begin
                        state_d   = S_LOCK;
                        get_new_d = 1'b1;
                    end
                end else begin
                    move_s = 1'b0;
                end
            end
`endif
            S_LOCK: begin
                // Cells stay put this cycle so the board absorbs them.
                if (org_y_q == SPAWN_Y) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    wait_first_d = 1'b1;
                    state_d      = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // The board raises busy one cycle late, so the first cycle is skipped.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!BOARD_BUSY) begin
                    state_d = S_SPAWN;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_SPAWN;
            end
        endcase

        if (move_s) begin
            save_x_d   = x_block;
            save_y_d   = y_block;
            save_sel_d = 1'b1;
        end else begin
            save_x_d   = save_x_q;
            save_y_d   = save_y_q;
            save_sel_d = 1'b0;
        end
    end

    // State registers with synchronous reset to a freshly spawned piece.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_SPAWN;
            org_x_q      <= SPAWN_X;
            org_y_q      <= SPAWN_Y;
            rot_q        <= 2'd0;
            color_q      <= next_block;
            cnt_q        <= '0;
            hist_q       <= 4'd0;
            save_x_q     <= 20'd0;
            save_y_q     <= 20'd0;
            save_sel_q   <= 1'b0;
            get_new_q    <= 1'b0;
            game_over_q  <= 1'b0;
            wait_first_q <= 1'b0;
`ifdef PIECE_HARD_DROP_EN
            hd_hist_q    <= 1'b0;
            drop_phase_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            org_x_q      <= org_x_d;
            org_y_q      <= org_y_d;
            rot_q        <= rot_d;
            color_q      <= color_d;
            cnt_q        <= cnt_d;
            hist_q       <= hist_d;
            save_x_q     <= save_x_d;
            save_y_q     <= save_y_d;
            save_sel_q   <= save_sel_d;
            get_new_q    <= get_new_d;
            game_over_q  <= game_over_d;
            wait_first_q <= wait_first_d;
`ifdef PIECE_HARD_DROP_EN
            hd_hist_q    <= hd_hist_d;
            drop_phase_q <= drop_phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl: spawn/gravity, left moves with wrap
// rejection, lock and respawn handshake, game over freeze, rotate-vs-left
// priority with soft drop, and (when PIECE_HARD_DROP_EN is defined) hard drop.
module tb_piece_ctrl;
    import piece_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame = 1'b0;
    logic        key_left = 1'b0, key_right = 1'b0, key_rot_l = 1'b0, key_rot_r = 1'b0;
    logic        soft_drop = 1'b0, hard_drop = 1'b0;
    block_color  next_block = O_BLK;
    logic [4:0]  can_move = 5'b11111;
    logic        BOARD_BUSY = 1'b0;
    logic [19:0] x_block, y_block, save_xblock, save_yblock;
    logic [19:0] x_move_left, y_move_left, x_move_right, y_move_right, x_move_down, y_move_down;
    logic [19:0] x_rotate_left, y_rotate_left, x_rotate_right, y_rotate_right;
    block_color  block;
    logic        get_new_block, game_over;

    int checks = 0;
    int failures = 0;

    piece_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(frame),
        .key_left(key_left), .key_right(key_right), .key_rot_l(key_rot_l), .key_rot_r(key_rot_r),
        .soft_drop(soft_drop), .hard_drop(hard_drop), .next_block(next_block),
        .can_move(can_move), .BOARD_BUSY(BOARD_BUSY),
        .x_block(x_block), .y_block(y_block), .save_xblock(save_xblock), .save_yblock(save_yblock),
        .x_move_left(x_move_left), .y_move_left(y_move_left),
        .x_move_right(x_move_right), .y_move_right(y_move_right),
        .x_move_down(x_move_down), .y_move_down(y_move_down),
        .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
        .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
        .block(block), .get_new_block(get_new_block), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    function automatic logic [19:0] p4(input int a, input int b, input int c, input int d);
        return {a[4:0], b[4:0], c[4:0], d[4:0]};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input block_color nb);
        @(negedge Clk);
        Reset = 1'b1;
        next_block = nb;
        key_left = 1'b0; key_right = 1'b0; key_rot_l = 1'b0; key_rot_r = 1'b0;
        soft_drop = 1'b0; hard_drop = 1'b0; can_move = 5'b11111; BOARD_BUSY = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic strobe();
        @(negedge Clk);
        frame = 1'b1;
        @(negedge Clk);
        frame = 1'b0;
    endtask

    initial begin
        // ---- 1: reset state, O piece gravity every 48 strobes
        do_reset(O_BLK);
        chk("rst_x", x_block, p4(4, 5, 4, 5));
        chk("rst_y", y_block, p4(0, 0, 1, 1));
        chk("rst_save_x", save_xblock, p4(4, 5, 4, 5));
        chk("rst_get_new", 20'(get_new_block), 20'd0);
        chk("rst_game_over", 20'(game_over), 20'd0);
        chk("rst_block", 20'(block), 20'(O_BLK));
        chk("cand_left_x", x_move_left, p4(3, 4, 3, 4));
        chk("cand_down_y", y_move_down, p4(1, 1, 2, 2));
        for (int i = 0; i < 47; i++) strobe();
        chk("grav_47_y", y_block, p4(0, 0, 1, 1));
        strobe();
        chk("grav_48_y", y_block, p4(1, 1, 2, 2));
        chk("grav_save_y", save_yblock, p4(0, 0, 1, 1));
        @(negedge Clk);
        chk("grav_save_track", save_yblock, p4(1, 1, 2, 2));

        // ---- 2: T piece, left presses down to column 0, wrap rejected
        do_reset(T_BLK);
        chk("t_spawn_x", x_block, p4(4, 3, 4, 5));
        chk("t_spawn_y", y_block, p4(0, 1, 1, 1));
        key_left = 1'b1; strobe();
        chk("left1_x", x_block, p4(3, 2, 3, 4));
        chk("left1_save", save_xblock, p4(4, 3, 4, 5));
        key_left = 1'b0; strobe();
        key_left = 1'b1; strobe();
        chk("left2_x", x_block, p4(2, 1, 2, 3));
        chk("left2_save", save_xblock, p4(3, 2, 3, 4));
        key_left = 1'b0; strobe();
        key_left = 1'b1; strobe();
        chk("left3_x", x_block, p4(1, 0, 1, 2));
        key_left = 1'b0; strobe();
        chk("wrap_cand", x_move_left, p4(0, 31, 0, 1));
        can_move = 5'b01111;
        key_left = 1'b1; strobe();
        chk("left4_rej", x_block, p4(1, 0, 1, 2));
        chk("left4_save", save_xblock, p4(1, 0, 1, 2));
        key_left = 1'b0; strobe();
        key_left = 1'b1; strobe();
        chk("left5_rej", x_block, p4(1, 0, 1, 2));

        // ---- 3: soft-drop O to row 18, lock, busy handshake, respawn
        do_reset(O_BLK);
        soft_drop = 1'b1;
        for (int i = 0; i < 54; i++) strobe();
        chk("sd_row18", y_block, p4(18, 18, 19, 19));
        can_move = 5'b11110;
        strobe(); strobe(); strobe();
        chk("lock_pulse", 20'(get_new_block), 20'd1);
        chk("lock_y_kept", y_block, p4(18, 18, 19, 19));
        BOARD_BUSY = 1'b1;
        next_block = T_BLK;
        @(negedge Clk);
        chk("lock_pulse_end", 20'(get_new_block), 20'd0);
        @(negedge Clk);
        @(negedge Clk);
        chk("wait_hold_y", y_block, p4(18, 18, 19, 19));
        BOARD_BUSY = 1'b0;
        can_move = 5'b11111;
        @(negedge Clk);
        @(negedge Clk);
        chk("respawn_x", x_block, p4(4, 3, 4, 5));
        chk("respawn_y", y_block, p4(0, 1, 1, 1));
        chk("respawn_block", 20'(block), 20'(T_BLK));
        chk("respawn_save", save_yblock, p4(0, 1, 1, 1));
        chk("no_game_over", 20'(game_over), 20'd0);

        // ---- 4: lock at spawn row -> game over, frozen, reset clears
        do_reset(O_BLK);
        soft_drop = 1'b1;
        can_move = 5'b11110;
        strobe(); strobe(); strobe();
        chk("go_lock_pulse", 20'(get_new_block), 20'd1);
        @(negedge Clk);
        chk("go_set", 20'(game_over), 20'd1);
        can_move = 5'b11111;
        for (int i = 0; i < 100; i++) begin
            key_left  = i[0];
            key_rot_r = i[1];
            strobe();
        end
        chk("go_frozen_x", x_block, p4(4, 5, 4, 5));
        chk("go_frozen_y", y_block, p4(0, 0, 1, 1));
        chk("go_sticky", 20'(game_over), 20'd1);
        chk("go_no_pulse", 20'(get_new_block), 20'd0);
        do_reset(T_BLK);
        chk("go_cleared", 20'(game_over), 20'd0);
        chk("go_reset_block", 20'(block), 20'(T_BLK));

        // ---- 5: rot_r beats left; left needs a fresh press; soft drop every 3
        key_rot_r = 1'b1; key_left = 1'b1; strobe();
        chk("rot_only_x", x_block, p4(4, 4, 5, 4));
        chk("rot_only_y", y_block, p4(0, 1, 1, 2));
        key_rot_r = 1'b0; strobe();
        chk("left_held_x", x_block, p4(4, 4, 5, 4));
        key_left = 1'b0; strobe();
        key_left = 1'b1; strobe();
        chk("left_repress_x", x_block, p4(3, 3, 4, 3));
        key_left = 1'b0;
        soft_drop = 1'b1;
        strobe();
        chk("sd_switch_tick", y_block, p4(1, 2, 2, 3));
        strobe(); strobe();
        chk("sd_wait", y_block, p4(1, 2, 2, 3));
        strobe();
        chk("sd_step3", y_block, p4(2, 3, 3, 4));

`ifdef PIECE_HARD_DROP_EN
        // ---- 6: hard drop O from row 0 on an empty board
        do_reset(O_BLK);
        hard_drop = 1'b1;
        strobe();
        hard_drop = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            can_move = {4'b1111, (y_block[4:0] != 5'd19)};
            @(negedge Clk);
            if (c == 36) chk("hd_land", y_block, p4(18, 18, 19, 19));
            if (c == 38) chk("hd_lock", 20'(get_new_block), 20'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
